mbt_level_walker: RTL and testbench
===================================

# mbt_level_walker

Sequential search controller for the multibit-tree tag sorter. Walks the tree from the root, one level per iteration. At each level it reads a node word from node memory and drives the matcher ripple array: `d` is the one-hot search digit and `m` is the node's child bitmap. It then consumes the array's `n` vector, priority-encodes the first marked child, and descends. The result is the smallest stored tag greater than or equal to the search tag, or a miss flag.

## Interface
Parameters:
- `LEVELS`, 3, number of tree levels (digits per tag)
- `DIGIT_W`, 2, bits per digit; fanout `F = 2**DIGIT_W`
- `ADDR_W`, 8, node memory address width
- `ROOT_ADDR`, 0, address of the root node

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  search request, sampled in IDLE only
- `tag_in`  in  `LEVELS*DIGIT_W`  search tag; level-0 digit in the MSBs
- `busy`  out  1  high from the cycle after start until `done`
- `done`  out  1  one-cycle pulse, result valid
- `found`  out  1  valid with `done`; 1 means a tag ≥ `tag_in` exists
- `result_tag`  out  `LEVELS*DIGIT_W`  found tag; 0 on miss
- `miss_level`  out  `clog2(LEVELS)` (min 1)  level at which the miss occurred; 0 when found
- `mem_rd_en`  out  1  node memory read strobe
- `mem_addr`  out  `ADDR_W`  node address
- `mem_rdata`  in  `F+ADDR_W`  `{child_base, bitmap}`; valid exactly 1 cycle after `mem_rd_en`
- `mat_d`  out  `F`  one-hot digit to matcher array
- `mat_m`  out  `F`  bitmap to matcher array
- `mat_n`  in  `F`  marked children from array; combinational, same cycle

## Operation
- The matcher array marks bitmap positions at or above the `d` position. The lowest set index of `mat_n` is therefore the smallest present child ≥ digit. The ripple runs from index 0 toward index F-1.
- States:
  - IDLE: `start` → ISSUE. Latch `tag_in`; set `addr = ROOT_ADDR`, `lvl = 0`, `exact = 1`.
  - ISSUE: `mem_rd_en = 1`, `mem_addr = addr` → EVAL.
  - EVAL:
    - Drive `mat_m = mem_rdata[F-1:0]`.
    - Drive `mat_d = onehot(exact ? digit[lvl] : 0)`.
    - If `mat_n == 0` → DONE with miss: `found = 0`, `miss_level = lvl`, `result_tag = 0`.
    - Otherwise:
      - `idx` = lowest set bit of `mat_n`; write it into the digit slot for `lvl` in `result_tag`.
      - `exact &= (idx == digit[lvl])`.
      - If `lvl == LEVELS-1` → DONE with `found = 1`.
      - Else `addr = child_base + idx` (modulo `2**ADDR_W`), `lvl++`, → ISSUE.
  - DONE: `done = 1` for one cycle → IDLE.
- Once any level selects `idx > digit`, every lower level selects the minimum present child (`d` = bit 0).
- No backtracking: a miss below level 0 is reported, not retried. Recovery is the caller's job.
- `start` is ignored while `busy`. `tag_in` is sampled only at acceptance.
- `mat_d` and `mat_m` are 0 outside EVAL. `mat_n` is ignored outside EVAL.

## Timing
- Reset values: state IDLE; `busy`, `done`, `found`, `mem_rd_en`, `mat_d`, `mat_m` = 0; `result_tag`, `miss_level`, `mem_addr` = 0.
- Async reset mid-search aborts immediately to IDLE. No `done` is produced for the aborted search.
- Latency for a full hit: `start` at edge 0 → `done` high in cycle `2*LEVELS+1`, which is 7 for the defaults.
- Latency for a miss at level k: `done` in cycle `2*k+3`.
- `found`, `result_tag` and `miss_level` are registered. They hold their values until the next `done`.
- `start` is accepted again in the cycle after `done`, giving back-to-back searches with 1 idle cycle.
- `mem_addr` is registered and stable during ISSUE.
- The memory returns `mem_rdata` in EVAL, and `mat_n` settles combinationally within that cycle.

## Test plan
- Exact hit:
  - Stimulus: root bitmap `0b0100`, base 1; node 3 bitmap `0b0010`, base 8; node 9 bitmap `0b1000`; `tag_in = 6'b10_01_11`.
  - Response: `found = 1`, `result_tag = 6'b100111`, `done` at cycle 7.
- Greater digit then minimum:
  - Stimulus: root `0b1010`; `tag_in` digit0 = 2; child at index 3 has bitmap `0b1100`.
  - Response: level 1 drives `mat_d = 0001`, selects index 2, and the result continues with minimum children below.
- Miss at level 1:
  - Stimulus: level-1 node bitmap `0b0001`, `digit[1] = 2`, exact path.
  - Response: `found = 0`, `miss_level = 1`, `result_tag = 0`, `done` at cycle 5.
- Empty root:
  - Stimulus: root bitmap `0`.
  - Response: miss at level 0, `done` at cycle 3.
- Protocol:
  - Stimulus: `start` held high through a search.
  - Response: exactly one search runs per acceptance; `busy` stays high and the second request is accepted only after IDLE is re-entered.
- Reset:
  - Stimulus: `rst_n` low during EVAL of level 1.
  - Response: all outputs are 0 immediately; no `done`; a new search afterward completes normally.

Source files
------------

// File: rtl/mbt_level_walker_if.sv
// mbt_level_walker_if: search request/result, node memory and matcher array signals of the level walker
//   slave  (walker): start, tag_in, mem_rdata, mat_n in; busy, done, found, result_tag, miss_level,
//                    mem_rd_en, mem_addr, mat_d, mat_m out
//   master (caller/memory/matcher side): the opposite directions
interface mbt_level_walker_if #(
  parameter int LEVELS  = 3,
  parameter int DIGIT_W = 2,
  parameter int ADDR_W  = 8
);
  localparam int F  = 2 ** DIGIT_W;
  localparam int TW = LEVELS * DIGIT_W;
  localparam int MW = LEVELS > 1 ? $clog2(LEVELS) : 1;
  logic              start;
  logic [TW-1:0]     tag_in;
  logic              busy;
  logic              done;
  logic              found;
  logic [TW-1:0]     result_tag;
  logic [MW-1:0]     miss_level;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [F+ADDR_W-1:0] mem_rdata;
  logic [F-1:0]      mat_d;
  logic [F-1:0]      mat_m;
  logic [F-1:0]      mat_n;
  modport slave (
    input  start, tag_in, mem_rdata, mat_n,
    output busy, done, found, result_tag, miss_level, mem_rd_en, mem_addr, mat_d, mat_m
  );
  modport master (
    output start, tag_in, mem_rdata, mat_n,
    input  busy, done, found, result_tag, miss_level, mem_rd_en, mem_addr, mat_d, mat_m
  );
endinterface

// File: rtl/mbt_level_walker.sv
// mbt_level_walker: walks the multibit tree root-down to find the smallest stored tag >= the search tag
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/tag_in request, busy/done/found/result_tag/miss_level result,
//                mem_rd_en/mem_addr/mem_rdata node memory, mat_d/mat_m/mat_n matcher array
module mbt_level_walker #(
  parameter int LEVELS    = 3,
  parameter int DIGIT_W   = 2,
  parameter int ADDR_W    = 8,
  parameter int ROOT_ADDR = 0
) (
  input logic clk,
  input logic rst_n,
  mbt_level_walker_if.slave bus
);
  localparam int F  = 2 ** DIGIT_W;
  localparam int TW = LEVELS * DIGIT_W;
  localparam int MW = LEVELS > 1 ? $clog2(LEVELS) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, EVAL, DONE} state_t;
  state_t            state_q, state_d;
  logic [TW-1:0]     tag_q, tag_d, res_q, res_d, rtag_q, rtag_d, res_w;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MW-1:0]     lvl_q, lvl_d, mlvl_q, mlvl_d;
  logic              exact_q, exact_d, found_q, found_d;
  logic [DIGIT_W-1:0] dig, idx;
  logic [F-1:0]      mat_d, mat_m;
  int                sh;
  // level 0 digit sits in the MSBs, so deeper levels shift toward bit 0
  assign sh  = (LEVELS - 1 - int'(lvl_q)) * DIGIT_W;
  assign dig = tag_q[sh +: DIGIT_W];
  // lowest marked child wins: it is the smallest present child >= the driven digit
  always_comb begin
    idx = '0;
    for (int i = F - 1; i >= 0; i--) if (bus.mat_n[i]) idx = DIGIT_W'(i);
  end
  always_comb begin
    res_w = res_q;
    res_w[sh +: DIGIT_W] = idx;
  end
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    lvl_d   = lvl_q;
    exact_d = exact_q;
    res_d   = res_q;
    found_d = found_q;
    rtag_d  = rtag_q;
    mlvl_d  = mlvl_q;
    mat_d   = '0;
    mat_m   = '0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = ISSUE;
        tag_d   = bus.tag_in;
        addr_d  = ADDR_W'(ROOT_ADDR);
        lvl_d   = '0;
        exact_d = 1'b1;
        res_d   = '0;
      end
      ISSUE: state_d = EVAL;
      EVAL: begin
        mat_m = bus.mem_rdata[F-1:0];
        // once a strictly greater digit was taken, every lower level just wants its minimum child
        mat_d = exact_q ? F'(1) << dig : F'(1);
        if (bus.mat_n == '0) begin
          state_d = DONE;
          found_d = 1'b0;
          rtag_d  = '0;
          mlvl_d  = lvl_q;
        end else begin
          res_d   = res_w;
          exact_d = exact_q && (idx == dig);
          if (lvl_q == MW'(LEVELS - 1)) begin
            state_d = DONE;
            found_d = 1'b1;
            rtag_d  = res_w;
            mlvl_d  = '0;
          end else begin
            state_d = ISSUE;
            addr_d  = bus.mem_rdata[F +: ADDR_W] + ADDR_W'(idx);
            lvl_d   = lvl_q + MW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
      addr_q  <= '0;
      lvl_q   <= '0;
      exact_q <= 1'b0;
      res_q   <= '0;
      found_q <= 1'b0;
      rtag_q  <= '0;
      mlvl_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      lvl_q   <= lvl_d;
      exact_q <= exact_d;
      res_q   <= res_d;
      found_q <= found_d;
      rtag_q  <= rtag_d;
      mlvl_q  <= mlvl_d;
    end
  end
  assign bus.busy       = state_q != IDLE;
  assign bus.done       = state_q == DONE;
  assign bus.found      = found_q;
  assign bus.result_tag = rtag_q;
  assign bus.miss_level = mlvl_q;
  assign bus.mem_rd_en  = state_q == ISSUE;
  assign bus.mem_addr   = addr_q;
  assign bus.mat_d      = mat_d;
  assign bus.mat_m      = mat_m;
endmodule

// File: tb/tb_mbt_level_walker.sv
// tb_mbt_level_walker: directed searches over a modelled node memory and matcher array, scoreboarded results
module tb_mbt_level_walker;
  typedef struct {
    logic       found;
    logic [5:0] tag;
    logic [1:0] ml;
    int         cyc;
    string      name;
  } exp_t;
  logic clk, rst_n, car;
  int cyc = 0, vec = 0, errs = 0, done_cnt = 0, rd = 0;
  logic [11:0] mem [256];
  exp_t sb[$];
  logic       obs_found [64];
  logic [5:0] obs_tag   [64];
  logic [1:0] obs_ml    [64];
  int         obs_cyc   [64];
  mbt_level_walker_if #(.LEVELS(3), .DIGIT_W(2), .ADDR_W(8)) bus ();
  mbt_level_walker #(.LEVELS(3), .DIGIT_W(2), .ADDR_W(8), .ROOT_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  always_comb begin
    car = 1'b0;
    bus.mat_n = '0;
    for (int i = 0; i < 4; i++) begin
      car = car | bus.mat_d[i];
      bus.mat_n[i] = bus.mat_m[i] & car;
    end
  end
  always @(negedge clk) if (rst_n && bus.done) begin
    obs_found[done_cnt % 64] <= bus.found;
    obs_tag[done_cnt % 64]   <= bus.result_tag;
    obs_ml[done_cnt % 64]    <= bus.miss_level;
    obs_cyc[done_cnt % 64]   <= cyc;
    done_cnt <= done_cnt + 1;
  end
  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    vec++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s observed %0h expected %0h", nm, got, want);
    end
  endtask
  task automatic node(input int a, input logic [7:0] base, input logic [3:0] bm);
    mem[a] = {base, bm};
  endtask
  task automatic go(input logic [5:0] t, input logic f, input logic [5:0] rt, input logic [1:0] ml,
                    input int lat, input string nm);
    exp_t e;
    @(negedge clk);
    bus.tag_in = t;
    bus.start  = 1'b1;
    e.found = f; e.tag = rt; e.ml = ml; e.cyc = cyc + 1 + lat; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic check_one();
    exp_t e;
    int n;
    e = sb.pop_front();
    n = 0;
    while (done_cnt <= rd && n < 60) begin
      @(negedge clk);
      n++;
    end
    cmp({e.name, "_done_seen"}, 32'(done_cnt > rd), 32'd1);
    if (done_cnt > rd) begin
      cmp({e.name, "_found"}, 32'(obs_found[rd % 64]), 32'(e.found));
      cmp({e.name, "_result_tag"}, 32'(obs_tag[rd % 64]), 32'(e.tag));
      cmp({e.name, "_miss_level"}, 32'(obs_ml[rd % 64]), 32'(e.ml));
      cmp({e.name, "_done_cycle"}, 32'(obs_cyc[rd % 64]), 32'(e.cyc));
      rd++;
    end
  endtask
  task automatic tree1();
    node(0, 8'd1, 4'b0100);
    node(3, 8'd8, 4'b0010);
    node(9, 8'd0, 4'b1000);
  endtask
  initial begin
    int dc;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.tag_in = '0;
    repeat (2) @(negedge clk);
    cmp("reset_outputs", 32'({bus.busy, bus.done, bus.found, bus.result_tag, bus.miss_level,
        bus.mem_rd_en, bus.mem_addr, bus.mat_d, bus.mat_m}), 32'd0);
    rst_n = 1'b1;
    tree1();
    go(6'b10_01_11, 1'b1, 6'b100111, 2'd0, 6, "exact_hit");
    check_one();
    node(0, 8'd16, 4'b1010);
    node(19, 8'd32, 4'b1100);
    node(34, 8'd0, 4'b0110);
    go(6'b10_11_11, 1'b1, 6'b111001, 2'd0, 6, "greater_then_min");
    @(posedge clk); #1;
    cmp("l0_mat_d", 32'(bus.mat_d), 32'b0100);
    cmp("l0_mat_m", 32'(bus.mat_m), 32'b1010);
    repeat (2) @(posedge clk); #1;
    cmp("l1_mat_d", 32'(bus.mat_d), 32'b0001);
    cmp("l1_mat_m", 32'(bus.mat_m), 32'b1100);
    check_one();
    node(0, 8'd1, 4'b0100);
    node(3, 8'd8, 4'b0001);
    go(6'b10_10_00, 1'b0, 6'd0, 2'd1, 4, "miss_l1");
    repeat (2) @(posedge clk); #1;
    cmp("l1_issue_rd_en", 32'(bus.mem_rd_en), 32'd1);
    cmp("l1_issue_addr", 32'(bus.mem_addr), 32'd3);
    check_one();
    node(0, 8'd0, 4'b0000);
    go(6'b01_01_01, 1'b0, 6'd0, 2'd0, 2, "empty_root");
    check_one();
    tree1();
    node(9, 8'd0, 4'b0001);
    go(6'b10_01_10, 1'b0, 6'd0, 2'd2, 6, "miss_l2");
    check_one();
    node(0, 8'd255, 4'b0100);
    node(1, 8'd200, 4'b0001);
    node(200, 8'd0, 4'b0010);
    go(6'b10_00_00, 1'b1, 6'b100001, 2'd0, 6, "addr_wrap");
    check_one();
    tree1();
    @(negedge clk);
    begin
      exp_t e;
      bus.tag_in = 6'b10_01_11;
      bus.start  = 1'b1;
      e.found = 1'b1; e.tag = 6'b100111; e.ml = 2'd0; e.cyc = cyc + 7; e.name = "held_start_1";
      sb.push_back(e);
      e.cyc = cyc + 15; e.name = "held_start_2";
      sb.push_back(e);
    end
    repeat (3) @(negedge clk);
    cmp("held_busy_mid", 32'(bus.busy), 32'd1);
    repeat (5) @(negedge clk);
    cmp("held_idle_gap", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    check_one();
    check_one();
    @(negedge clk);
    bus.tag_in = 6'b10_01_11;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk); #1;
    cmp("pre_reset_l1_mat_m", 32'(bus.mat_m), 32'b0010);
    rst_n = 1'b0;
    #1;
    cmp("abort_outputs", 32'({bus.busy, bus.done, bus.found, bus.result_tag, bus.miss_level,
        bus.mem_rd_en, bus.mem_addr, bus.mat_d, bus.mat_m}), 32'd0);
    dc = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    cmp("no_done_after_abort", 32'(done_cnt), 32'(dc));
    go(6'b10_01_11, 1'b1, 6'b100111, 2'd0, 6, "post_reset");
    check_one();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
